// File: rtl/player_damage_unit.sv
// Player HP bookkeeping: applies damage requests with a four-phase handshake,
// edge-triggered heals, a hit-flash window and a sticky death state.
module player_damage_unit #(
  parameter int MAX_HP       = 100,
  parameter int HEAL_AMT     = 20,
  parameter int FLASH_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startDmg,
  input  logic [7:0] damage,
  input  logic       heal,
  output logic       isDmgComplete,
  output logic       isDeath,
  output logic [7:0] playerHP,
  output logic       hitFlash
);

  localparam logic [8:0] MAX_W   = 9'(MAX_HP);
  localparam logic [8:0] HEAL_W  = 9'(HEAL_AMT);
  localparam logic [7:0] FLASH_W = 8'(FLASH_CYCLES);

  typedef enum logic [2:0] {IDLE, APPLY, FLASH, ACK, DEAD} state_t;

  state_t     state, state_next;
  logic [7:0] hp;
  logic [7:0] dmg_q;
  logic [7:0] flash_cnt;
  logic       heal_q;
  logic       death;
  logic       dead_ack;
  logic       heal_evt;
  logic [7:0] hp_applied;

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (b >= a) ? 8'd0 : (a - b);
  endfunction

  // Nine-bit sum so a large heal near 255 cannot wrap before the clamp.
  function automatic logic [7:0] sat_heal(input logic [7:0] a);
    logic [8:0] sum;
    sum = {1'b0, a} + HEAL_W;
    return (sum > MAX_W) ? MAX_W[7:0] : sum[7:0];
  endfunction

  assign heal_evt   = heal & ~heal_q;
  assign hp_applied = sat_sub(hp, dmg_q);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (startDmg) state_next = APPLY;
      APPLY: begin
        if (hp_applied == 8'd0 || dmg_q == 8'd0) state_next = ACK;
        else                                      state_next = FLASH;
      end
      FLASH: if (flash_cnt <= 8'd1) state_next = ACK;
      ACK:   if (!startDmg) state_next = death ? DEAD : IDLE;
      DEAD:  state_next = DEAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hp        <= MAX_W[7:0];
      dmg_q     <= 8'd0;
      flash_cnt <= 8'd0;
      heal_q    <= 1'b0;
      death     <= 1'b0;
      dead_ack  <= 1'b0;
    end else begin
      state    <= state_next;
      heal_q   <= heal;
      // In DEAD the acknowledge simply follows the request one cycle later.
      dead_ack <= (state == DEAD) && startDmg;
      case (state)
        IDLE: begin
          if (heal_evt) hp <= sat_heal(hp);
          if (startDmg) dmg_q <= damage;
        end
        APPLY: begin
          hp <= hp_applied;
          if (hp_applied == 8'd0) death <= 1'b1;
          flash_cnt <= (state_next == FLASH) ? FLASH_W : 8'd0;
        end
        FLASH: flash_cnt <= flash_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  assign playerHP      = hp;
  assign isDeath       = death;
  assign hitFlash      = (state == FLASH);
  assign isDmgComplete = (state == ACK) || ((state == DEAD) && dead_ack);

endmodule

// File: tb/tb_player_damage_unit.sv
// Scoreboard bench for player_damage_unit: each request pushes its expected
// outcome, and a monitor pops and compares when the acknowledge rises.
module tb_player_damage_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       startDmg;
  logic [7:0] damage;
  logic       heal;
  logic       isDmgComplete;
  logic       isDeath;
  logic [7:0] playerHP;
  logic       hitFlash;

  player_damage_unit #(.MAX_HP(100), .HEAL_AMT(20), .FLASH_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .startDmg(startDmg), .damage(damage), .heal(heal),
    .isDmgComplete(isDmgComplete), .isDeath(isDeath), .playerHP(playerHP),
    .hitFlash(hitFlash)
  );

  always #5 clk = ~clk;

  typedef struct {
    int start;
    int lat;
    int flash_base;
    int flash;
    int hp;
    int death;
  } item_t;

  item_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int flash_total = 0;
  logic ack_prev = 1'b0;
  int model_hp = 100;
  int model_dead = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    item_t it;
    if (isDmgComplete && !ack_prev) begin
      if (q.size() == 0) begin
        check_eq("unexpected_ack", 1, 0);
      end else begin
        it = q.pop_front();
        check_eq("ack_latency", cyc - it.start, it.lat);
        check_eq("ack_hp", int'(playerHP), it.hp);
        check_eq("ack_death", int'(isDeath), it.death);
        check_eq("flash_cycles", flash_total - it.flash_base, it.flash);
      end
    end
    if (hitFlash) flash_total++;
    ack_prev = isDmgComplete;
  end

  // Called at a negedge; ends at a negedge with startDmg low and ack checked low.
  task automatic do_request(input int d, input int heal_at);
    item_t it;
    int hp_pre, k;
    bit done;
    hp_pre = model_hp;
    if (heal_at == 0 && !model_dead) hp_pre = (model_hp + 20 > 100) ? 100 : model_hp + 20;
    it.start = cyc;
    it.flash_base = flash_total;
    it.hp = (d >= hp_pre) ? 0 : hp_pre - d;
    if (model_dead) begin
      it.lat = 1; it.flash = 0; it.death = 1;
    end else if (it.hp == 0) begin
      it.lat = 2; it.flash = 0; it.death = 1;
    end else if (d == 0) begin
      it.lat = 2; it.flash = 0; it.death = 0;
    end else begin
      it.lat = 6; it.flash = 4; it.death = 0;
    end
    q.push_back(it);
    damage = 8'(d);
    startDmg = 1'b1;
    if (heal_at == 0) heal = 1'b1;
    k = 0;
    done = 1'b0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (k == heal_at) heal = 1'b1;
      if (k == 1 && heal_at == 0 && !model_dead) check_eq("hp_heal_first", int'(playerHP), hp_pre);
      if (k == 2) check_eq("hp_after_apply", int'(playerHP), it.hp);
      if (isDmgComplete) done = 1'b1;
    end
    if (!done) check_eq("ack_timeout", 0, 1);
    startDmg = 1'b0;
    heal = 1'b0;
    @(negedge clk);
    check_eq("ack_drop", int'(isDmgComplete), 0);
    model_hp = it.hp;
    if (it.hp == 0) model_dead = 1;
  endtask

  // Rising heal edge, held for a few cycles, then released.
  task automatic heal_edge(input int exp_hp);
    heal = 1'b1;
    @(negedge clk);
    check_eq("heal_edge_hp", int'(playerHP), exp_hp);
    repeat (3) @(negedge clk);
    check_eq("heal_hold_hp", int'(playerHP), exp_hp);
    heal = 1'b0;
    @(negedge clk);
    model_hp = exp_hp;
  endtask

  initial begin
    reset = 1'b1;
    startDmg = 1'b0;
    damage = 8'd0;
    heal = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_hp", int'(playerHP), 100);
    check_eq("rst_death", int'(isDeath), 0);
    check_eq("rst_ack", int'(isDmgComplete), 0);
    check_eq("rst_flash", int'(hitFlash), 0);
    reset = 1'b0;
    @(negedge clk);

    do_request(10, -1);            // 100 -> 90 with full flash
    heal_edge(100);                // saturates at MAX_HP
    heal_edge(100);                // second edge at ceiling
    do_request(30, -1);            // 100 -> 70
    heal_edge(90);                 // held heal applies once
    do_request(0, -1);             // zero damage, no flash
    do_request(40, 3);             // heal during FLASH is dropped: 90 -> 50
    do_request(30, 0);             // heal then damage: 50 -> 70 -> 40

    // Reset in the middle of a flash with the request still held.
    damage = 8'd20;
    startDmg = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_flash", int'(hitFlash), 1);
    reset = 1'b1;
    #1;
    check_eq("midrst_hp", int'(playerHP), 100);
    check_eq("midrst_ack", int'(isDmgComplete), 0);
    check_eq("midrst_flash", int'(hitFlash), 0);
    repeat (2) @(negedge clk);
    check_eq("midrst_ack_held", int'(isDmgComplete), 0);
    reset = 1'b0;
    model_hp = 100;
    do_request(20, -1);            // still-high request re-accepted: 100 -> 80

    do_request(255, -1);           // lethal, no wrap
    heal_edge(0);                  // heal ignored when dead
    check_eq("dead_idle_ack", int'(isDmgComplete), 0);
    do_request(5, -1);             // dead state still acknowledges
    check_eq("dead_hp_final", int'(playerHP), 0);

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/player_damage_unit.md
PLAYER_DAMAGE_UNIT -- requirements
Module: player_damage_unit

Interface
REQ-001 SHALL provide parameter MAX_HP, default 100, meaning player HP ceiling and reset value.
REQ-002 SHALL provide parameter HEAL_AMT, default 20, meaning HP added per accepted heal event.
REQ-003 SHALL provide parameter FLASH_CYCLES, default 4, meaning hit-flash duration in clocks (range 1..255).
REQ-004 SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: startDmg  input  1  damage request from the game state machine; held high until isDmgComplete is seen.
REQ-007 SHALL have port: damage  input  8  unsigned damage amount, sampled when a request is accepted.
REQ-008 SHALL have port: heal  input  1  heal request, level signal; only its rising edge is an event.
REQ-009 SHALL have port: isDmgComplete  output  1  request-done acknowledge back to the state machine.
REQ-010 SHALL have port: isDeath  output  1  sticky high once player HP reaches 0.
REQ-011 SHALL have port: playerHP  output  8  current player HP, unsigned.
REQ-012 SHALL have port: hitFlash  output  1  high during the hit-flash window, for the display.

Function
REQ-013 SHALL implement FSM states IDLE, APPLY, FLASH, ACK, DEAD.
REQ-014 IDLE: startDmg high -> latch damage into an internal 8-bit register and go to APPLY next cycle.
REQ-015 APPLY (one cycle): playerHP <= playerHP - latched damage, saturating at 0 (no wrap).
REQ-016 APPLY exit: if new HP is 0 -> ACK with isDeath set; else if latched damage is 0 -> ACK; else -> FLASH with the flash counter loaded to FLASH_CYCLES.
REQ-017 FLASH: hitFlash = 1; counter decrements each cycle; on the cycle the counter reaches 0 -> ACK.
REQ-018 ACK: isDmgComplete = 1; stay until startDmg is low, then go to IDLE, or to DEAD if isDeath is set.
REQ-019 Four-phase handshake: isDmgComplete SHALL fall on the first clock after startDmg is sampled low; a new request requires startDmg low for at least one cycle in IDLE.
REQ-020 Request latency: isDmgComplete high 2 + FLASH_CYCLES cycles after startDmg is first sampled high (nonzero, non-lethal damage); 2 cycles for zero or lethal damage.
REQ-021 Heal edge detect: register heal; event = heal & ~heal_q.
REQ-022 A heal event in IDLE SHALL set playerHP <= min(playerHP + HEAL_AMT, MAX_HP), computed with 9-bit intermediate to avoid overflow.
REQ-023 A heal event in APPLY, FLASH, ACK or DEAD SHALL be discarded (not queued).
REQ-024 Simultaneous startDmg and heal event in IDLE: apply the heal in that cycle; damage then applies in APPLY to the healed HP.
REQ-025 DEAD: isDeath = 1, HP held at 0, heal ignored; startDmg high -> isDmgComplete = 1 combinationally from state the next cycle, low again one cycle after startDmg falls (no hang).
REQ-026 hitFlash SHALL be 0 in every state except FLASH; isDmgComplete SHALL be 0 in every state except ACK and DEAD.
REQ-027 playerHP SHALL never exceed MAX_HP and never wrap below 0.

Reset
REQ-028 reset high SHALL immediately force: state IDLE, playerHP = MAX_HP, isDeath = 0, isDmgComplete = 0, hitFlash = 0, flash counter = 0, latched damage = 0, heal_q = 0.
REQ-029 reset mid-request (any state) SHALL abort the request without acknowledge; after release, a still-high startDmg is accepted as a new request.

Verification
REQ-030 Reset release, startDmg=1 with damage=10 -> HP 90 two cycles later, hitFlash high 4 cycles, isDmgComplete high 6 cycles after request; drop startDmg -> isDmgComplete low next cycle.
REQ-031 HP 90, heal 0->1 in IDLE -> HP 100 (saturated, not 110); heal held high -> no further change; second rising edge at HP 100 -> stays 100.
REQ-032 damage=255 at HP 100 -> HP 0 (no wrap), isDeath=1, no hitFlash, ack after 2 cycles; then heal edge -> HP stays 0; new startDmg -> ack, HP 0.
REQ-033 damage=0 -> HP unchanged, hitFlash never high, ack 2 cycles after request.
REQ-034 heal edge during FLASH -> discarded, HP unchanged after ack; heal edge and startDmg (damage=30) same cycle at HP 50 -> HP 70 then 40.
REQ-035 reset asserted during FLASH with startDmg held high -> HP 100, no ack; after release request re-accepted, HP 100-damage.
